// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - dual-rail link types, rail indices and codeword helpers
package dr_pkg;

    localparam int DR_F = 0;
    localparam int DR_T = 1;

    typedef logic [1:0] dr_bit_t;

    typedef enum logic {
        WAIT_DATA,
        WAIT_NULL
    } dr_rx_state_e;

    function automatic logic dr_is_valid(input dr_bit_t b);
        return b[DR_T] ^ b[DR_F];
    endfunction

    function automatic logic dr_is_null(input dr_bit_t b);
        return ~(b[DR_T] | b[DR_F]);
    endfunction

    // An illegal 11 code decodes as '1' because only the true rail is looked at.
    function automatic logic dr_decode(input dr_bit_t b);
        return b[DR_T];
    endfunction

endpackage

// File: rtl/dr_sync.sv
// rtl/dr_sync.sv - N-stage single-bit synchroniser with synchronous clear
module dr_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], d};
        end
    end

    assign q = stages[N-1];

endmodule

// File: rtl/dr_link_rx_sync.sv
// rtl/dr_link_rx_sync.sv - four-phase dual-rail link receiver into a clocked valid/ready word
module dr_link_rx_sync
    import dr_pkg::*;
#(
    parameter int    WIDTH       = 32,
    parameter string ENC         = "FP",
    parameter int    RAIL_NUM    = 2,
    parameter int    SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]    in,
    output logic                              ack_o,
    output logic [WIDTH-1:0]                  data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              err_o
);

    if (ENC != "FP" || RAIL_NUM != 2 || SYNC_STAGES < 2) begin : g_bad_cfg
        $fatal(1, "dr_link_rx_sync: only four-phase dual-rail with >=2 sync stages is supported");
    end

    logic             all_valid;
    logic             all_null;
    logic             any_ill;
    logic             all_valid_s;
    logic             all_null_s;
    logic             any_ill_s;
    logic [WIDTH-1:0] decoded;
    dr_rx_state_e     state;

    // Completion detection runs on raw rails; only its synchronised result steers the FSM.
    always_comb begin
        all_valid = 1'b1;
        all_null  = 1'b1;
        any_ill   = 1'b0;
        decoded   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            all_valid  = all_valid & dr_is_valid(in[i]);
            all_null   = all_null & dr_is_null(in[i]);
            any_ill    = any_ill | (in[i][DR_T] & in[i][DR_F]);
            decoded[i] = dr_decode(in[i]);
        end
    end

    dr_sync #(.N(SYNC_STAGES)) u_sync_valid (.clk(clk), .rst(rst), .d(all_valid), .q(all_valid_s));
    dr_sync #(.N(SYNC_STAGES)) u_sync_null  (.clk(clk), .rst(rst), .d(all_null),  .q(all_null_s));
    dr_sync #(.N(SYNC_STAGES)) u_sync_ill   (.clk(clk), .rst(rst), .d(any_ill),   .q(any_ill_s));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_DATA;
            ack_o   <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            err_o <= err_o | any_ill_s;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                WAIT_DATA: begin
                    // Holding ack low while the buffer is full back-pressures the sender.
                    if (all_valid_s && (!valid_o || ready_i)) begin
                        data_o  <= decoded;
                        valid_o <= 1'b1;
                        ack_o   <= 1'b1;
                        state   <= WAIT_NULL;
                    end
                end
                WAIT_NULL: begin
                    if (all_null_s) begin
                        ack_o <= 1'b0;
                        state <= WAIT_DATA;
                    end
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= WAIT_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dr_link_rx_sync.sv
// tb/tb_dr_link_rx_sync.sv - directed bench for the dual-rail link receiver
module tb_dr_link_rx_sync;

    logic             clk;
    logic             rst;
    logic [31:0][1:0] rails;
    logic             ack_o;
    logic [31:0]      data_o;
    logic             valid_o;
    logic             ready_i;
    logic             err_o;

    int n_assert = 0;
    int n_fail   = 0;

    dr_link_rx_sync #(
        .WIDTH(32),
        .ENC("FP"),
        .RAIL_NUM(2),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(rails),
        .ack_o(ack_o),
        .data_o(data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic link_driver(input logic [31:0] w);
        for (int i = 0; i < 32; i++) rails[i] = w[i] ? 2'b10 : 2'b01;
    endtask

    task automatic link_null();
        rails = '0;
    endtask

    // Counts rising edges until ack_o reaches lvl; returns -1 on timeout.
    task automatic wait_ack(input logic lvl, output int cnt);
        cnt = 0;
        while (1) begin
            @(posedge clk); #1;
            cnt++;
            if (ack_o === lvl) break;
            if (cnt >= 50) begin
                cnt = -1;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input string tag);
        int c;
        @(negedge clk);
        link_driver(w);
        wait_ack(1'b1, c);
        chk({tag, "_ack_rise"}, 32'(c), 32'd3);
        chk({tag, "_data"}, data_o, w);
        chk({tag, "_valid"}, 32'(valid_o), 32'd1);
        link_null();
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(valid_o), 32'd0);
        c = 1;
        while (ack_o !== 1'b0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk({tag, "_ack_fall"}, 32'(c), 32'd3);
    endtask

    logic [31:0] words [5] = '{32'h0, 32'h0, 32'hFFFFFFF6, 32'h0000000C, 32'hFFFFFFFF};

    initial begin
        int c;
        logic seen;
        rst = 1'b1;
        ready_i = 1'b0;
        link_null();

        // Reset state held across ten cycles
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'h0 || err_o !== 1'b0) seen = 1'b1;
        end
        chk("reset_outputs", 32'(seen), 32'd0);
        chk("reset_data", data_o, 32'h0);
        rst = 1'b0;

        // Back-to-back words with ready high
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) send_word(words[i], $sformatf("b2b%0d", i));

        // Backpressure: second word waits until the first is taken
        @(negedge clk);
        ready_i = 1'b0;
        link_driver(32'd12);
        wait_ack(1'b1, c);
        chk("bp_ack12", 32'(c), 32'd3);
        link_null();
        wait_ack(1'b0, c);
        chk("bp_ack12_fall", 32'(c), 32'd3);
        @(negedge clk);
        link_driver(32'd15);
        repeat (10) @(negedge clk);
        chk("bp_ack_held", 32'(ack_o), 32'd0);
        chk("bp_data_held", data_o, 32'd12);
        chk("bp_valid_held", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_cap15_ack", 32'(ack_o), 32'd1);
        chk("bp_cap15_data", data_o, 32'd15);
        chk("bp_cap15_valid", 32'(valid_o), 32'd1);
        @(negedge clk);
        ready_i = 1'b0;
        link_null();
        wait_ack(1'b0, c);
        chk("bp_ack15_fall", 32'(c), 32'd3);
        chk("bp_15_still_valid", 32'(valid_o), 32'd1);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_15_taken", 32'(valid_o), 32'd0);

        // Partial codeword: bit 31 still null
        @(negedge clk);
        link_driver(32'h000000A5);
        rails[31] = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_o !== 1'b0 || valid_o !== 1'b0) seen = 1'b1;
        end
        chk("partial_hold", 32'(seen), 32'd0);
        rails[31] = 2'b10;
        wait_ack(1'b1, c);
        chk("partial_complete_lat", 32'(c), 32'd3);
        chk("partial_data", data_o, 32'h800000A5);
        link_null();
        wait_ack(1'b0, c);
        chk("partial_ack_fall", 32'(c), 32'd3);

        // Illegal code on bit 5 sets sticky error
        @(negedge clk);
        rails[5] = 2'b11;
        c = 0;
        while (err_o !== 1'b1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("err_lat", 32'(c), 32'd3);
        link_null();
        repeat (10) @(negedge clk);
        chk("err_sticky", 32'(err_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("err_cleared", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in WAIT_NULL with the codeword still held
        ready_i = 1'b0;
        link_driver(32'h00001234);
        wait_ack(1'b1, c);
        chk("rst_mid_ack", 32'(c), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack_low", 32'(ack_o), 32'd0);
        chk("rst_mid_valid_low", 32'(valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ack(1'b1, c);
        chk("rst_recap_lat", 32'(c), 32'd3);
        chk("rst_recap_data", data_o, 32'h00001234);
        chk("rst_recap_valid", 32'(valid_o), 32'd1);
        link_null();
        wait_ack(1'b0, c);
        chk("rst_recap_fall", 32'(c), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
